retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//   Synthesizable commit-stage trace capture for the OoO core. Snoops N_PORTS retire ports each cycle.
//   Compacts valid retirements in port order into a circular buffer of DEPTH entries, each cycle-stamped.
//   Keeps performance counters and exposes a valid/ready drain port, so commit traces survive on
//   silicon/FPGA without $display.
// PARAMETERS
//   N_PORTS  2   retire ports snooped per cycle (1..4)
//   DEPTH    16  trace entries; power of two, >= N_PORTS
//   RD_W     6   physical register tag width
//   DATA_W   32  retire data width
//   CYC_W    32  cycle/perf counter width
// PORTS
//   clk         in   1                clock, rising edge
//   rst         in   1                asynchronous, active-low reset
//   en          in   1                capture/count enable
//   clear       in   1                synchronous flush of buffer and counters
//   wrap_mode   in   1                0 = stop-on-full (drop new), 1 = overwrite oldest
//   ret_valid   in   N_PORTS          per-port retire valid
//   ret_rd      in   N_PORTS*RD_W     per-port dest tag; port p at [p*RD_W +: RD_W]
//   ret_oldrd   in   N_PORTS*RD_W     per-port old dest tag (freed reg)
//   ret_data    in   N_PORTS*DATA_W   per-port retire data
//   rd_ready    in   1                drain consumer ready
//   rd_valid    out  1                head entry valid (= !empty)
//   rd_port     out  clog2(N_PORTS)   head: retire port index (width >= 1)
//   rd_rd       out  RD_W             head: dest tag
//   rd_oldrd    out  RD_W             head: old dest tag
//   rd_data     out  DATA_W           head: data
//   rd_cycle    out  CYC_W            head: cycle stamp
//   count       out  clog2(DEPTH)+1   occupied entries
//   full, empty out  1                count==DEPTH / count==0
//   overflow    out  1                sticky: any entry dropped or overwritten since reset/clear
//   cycle_cnt   out  CYC_W            cycles elapsed while en
//   retired_cnt out  CYC_W            total valid retire slots seen while en
//   dropped_cnt out  CYC_W            entries dropped (stop) or overwritten (wrap)
// BEHAVIOUR
//   Reset (rst=0, async): pointers, count, all counters, overflow = 0; empty=1, rd_valid=0.
//   Reset also forces rd_* = 0; storage contents need not be cleared.
//   clear=1 at edge: same result as reset, synchronous; overrides en, pushes and pops that cycle.
//   Drain: rd_* = mem[rd_ptr] combinationally (FWFT). Pop when rd_valid && rd_ready. rd_* = 0 when empty.
//   Pop is independent of en.
//   Push (en=1 only): let n = popcount(ret_valid). Valid slots are written in ascending port order.
//   Writes go to consecutive entries from wr_ptr; invalid ports leave no holes.
//   Each written entry stamps the pre-increment cycle_cnt of that cycle.
//   Space = DEPTH - count + (pop ? 1 : 0); a same-cycle pop frees its entry for pushes.
//   Stop mode: the first min(n, space) slots are written; the rest are discarded.
//   In stop mode, dropped_cnt += n - accepted.
//   Wrap mode: all n slots are written. Excess e = max(0, n - space).
//   In wrap mode, rd_ptr advances by e beyond any pop, count saturates at DEPTH, and dropped_cnt += e.
//   overflow is set whenever a cycle has a nonzero drop or overwrite; it clears only on reset or clear.
//   en=1: cycle_cnt += 1 and retired_cnt += n every cycle. en=0: counters hold and no pushes occur.
//   All counters and pointers wrap modulo their width; pointers are log2(DEPTH) bits.
//   count' = count - pop + accepted_or_written - e. Latency: entry visible on rd_* the cycle after its
//   push edge.
//   Changing wrap_mode mid-run takes effect on the next edge, with no flush.
// TESTING  (N_PORTS=2, DEPTH=4)
//   1 Assert rst low mid-run with count=3 -> next sample: count=0, empty=1, rd_valid=0, all counters=0.
//   2 cycle_cnt=3, ret_valid=11, rd=5/7, data=10/20 -> two entries: port0{5,10,cyc3} then
//     port1{7,20,cyc3}; count=2.
//   3 ret_valid=10 only (rd=9) when empty -> one entry at head with rd_port=1; no hole.
//   4 Stop mode, count=3, ret_valid=11, no pop -> port0 accepted, port1 dropped; full=1,
//     overflow=1, dropped_cnt=1.
//   5 Stop mode, full, pop + ret_valid=11 -> head popped, one accepted, one dropped; count stays 4.
//   6 Wrap mode, buffer holds A,B,C,D; push E,F -> head=C, order C,D,E,F; count=4; dropped_cnt=2;
//     overflow=1.
//   7 clear with pushes pending -> next cycle empty, counters 0; en=0 for 5 cycles -> cycle_cnt unchanged.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Commit-stage trace capture. Each cycle the N_PORTS retire ports are snooped
//   and the valid ones are compacted, in ascending port order, into a circular
//   buffer of DEPTH cycle-stamped entries. The oldest entry is presented on a
//   first-word-fall-through valid/ready drain port. In stop mode new entries are
//   dropped when the buffer is full; in wrap mode the oldest entries are
//   overwritten. Performance counters track elapsed cycles, retirements and
//   drops/overwrites.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   en                capture / counter enable
//   clear             synchronous flush of buffer, counters and overflow flag
//   wrap_mode         0 = stop-on-full, 1 = overwrite oldest
//   ret_valid/rd/oldrd/data   per-port retire snoop, port p at [p*W +: W]
//   rd_ready          drain consumer ready
//   rd_valid, rd_*    head entry (all zero when empty)
//   count/full/empty  occupancy
//   overflow          sticky: some entry dropped or overwritten
//   cycle_cnt, retired_cnt, dropped_cnt   performance counters
module retire_trace_buffer #(
  parameter int N_PORTS = 2,
  parameter int DEPTH   = 16,
  parameter int RD_W    = 6,
  parameter int DATA_W  = 32,
  parameter int CYC_W   = 32,
  localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      wrap_mode,
  input  logic [N_PORTS-1:0]        ret_valid,
  input  logic [N_PORTS*RD_W-1:0]   ret_rd,
  input  logic [N_PORTS*RD_W-1:0]   ret_oldrd,
  input  logic [N_PORTS*DATA_W-1:0] ret_data,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [PORT_W-1:0]         rd_port,
  output logic [RD_W-1:0]           rd_rd,
  output logic [RD_W-1:0]           rd_oldrd,
  output logic [DATA_W-1:0]         rd_data,
  output logic [CYC_W-1:0]          rd_cycle,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [CYC_W-1:0]          cycle_cnt,
  output logic [CYC_W-1:0]          retired_cnt,
  output logic [CYC_W-1:0]          dropped_cnt
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [RD_W-1:0]   rd;
    logic [RD_W-1:0]   oldrd;
    logic [DATA_W-1:0] data;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            new_entry [N_PORTS];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  slot_off [N_PORTS];
  logic [CNT_W-1:0]  n_valid, space, written, excess, dropped_now;
  logic              pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;

  // Compaction: each valid port's slot offset is the number of valid ports
  // below it, so invalid ports leave no holes in the buffer.
  always_comb begin
    n_valid = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      // NOTE: blocking assignments here are intentional -- n_valid is a running
      // sum that must update within this evaluation; registers below use <=.
      slot_off[p] = n_valid;
      if (ret_valid[p]) n_valid = n_valid + ONE_C;
      new_entry[p] = '{port:  PORT_W'(p),
                       rd:    ret_rd[p*RD_W +: RD_W],
                       oldrd: ret_oldrd[p*RD_W +: RD_W],
                       data:  ret_data[p*DATA_W +: DATA_W],
                       cycle: cycle_cnt};
    end
  end

  // Admission: a same-cycle pop frees one entry. Stop mode truncates the
  // batch; wrap mode writes it all and evicts the excess from the head.
  always_comb begin
    space       = DEPTH_C - count + CNT_W'(pop);
    written     = '0;
    excess      = '0;
    dropped_now = '0;
    if (en) begin
      if (wrap_mode) begin
        written = n_valid;
        if (n_valid > space) excess = n_valid - space;
        dropped_now = excess;
      end else begin
        written     = (n_valid < space) ? n_valid : space;
        dropped_now = n_valid - written;
      end
    end
  end

  // NOTE: storage has no reset -- the pointers and count define which entries
  // are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rst && !clear) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (ret_valid[p] && (slot_off[p] < written))
          mem[wr_ptr + slot_off[p][PTR_W-1:0]] <= new_entry[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      dropped_cnt <= '0;
    end else if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      dropped_cnt <= '0;
    end else begin
      // Eviction of the excess moves the head past overwritten entries.
      rd_ptr <= rd_ptr + PTR_W'(pop) + excess[PTR_W-1:0];
      wr_ptr <= wr_ptr + written[PTR_W-1:0];
      count  <= count - CNT_W'(pop) + written - excess;
      if (dropped_now != '0) overflow <= 1'b1;
      if (en) begin
        cycle_cnt   <= cycle_cnt + CYC_W'(1);
        retired_cnt <= retired_cnt + CYC_W'(n_valid);
        dropped_cnt <= dropped_cnt + CYC_W'(dropped_now);
      end
    end
  end

  // First-word-fall-through head; forced to zero when nothing is stored.
  assign head = mem[rd_ptr];

  always_comb begin
    rd_port  = '0;
    rd_rd    = '0;
    rd_oldrd = '0;
    rd_data  = '0;
    rd_cycle = '0;
    if (!empty) begin
      rd_port  = head.port;
      rd_rd    = head.rd;
      rd_oldrd = head.oldrd;
      rd_data  = head.data;
      rd_cycle = head.cycle;
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer
//   Directed bench for retire_trace_buffer (N_PORTS=2, DEPTH=4). Stimulus pushes
//   hand-computed expected entries into a scoreboard queue; a monitor on the
//   falling edge pops and compares whenever the drain port hands over an entry.
//   Occupancy, flags and counters are checked directly after each step.
module tb_retire_trace_buffer;

  localparam int N_PORTS = 2;
  localparam int DEPTH   = 4;
  localparam int RD_W    = 6;
  localparam int DATA_W  = 32;
  localparam int CYC_W   = 32;

  typedef struct {
    logic [0:0]  port;
    logic [5:0]  rd;
    logic [5:0]  oldrd;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_entry_t;

  logic                      tb_clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      clear;
  logic                      wrap_mode;
  logic [N_PORTS-1:0]        ret_valid;
  logic [N_PORTS*RD_W-1:0]   ret_rd;
  logic [N_PORTS*RD_W-1:0]   ret_oldrd;
  logic [N_PORTS*DATA_W-1:0] ret_data;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [0:0]                rd_port;
  logic [RD_W-1:0]           rd_rd;
  logic [RD_W-1:0]           rd_oldrd;
  logic [DATA_W-1:0]         rd_data;
  logic [CYC_W-1:0]          rd_cycle;
  logic [2:0]                count;
  logic                      full;
  logic                      empty;
  logic                      overflow;
  logic [CYC_W-1:0]          cycle_cnt;
  logic [CYC_W-1:0]          retired_cnt;
  logic [CYC_W-1:0]          dropped_cnt;

  int         checks = 0;
  int         errors = 0;
  exp_entry_t sb [$];
  exp_entry_t mon_e;

  retire_trace_buffer #(
    .N_PORTS(N_PORTS), .DEPTH(DEPTH), .RD_W(RD_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
  ) dut (
    .clk(tb_clk), .rst(rst), .en(en), .clear(clear), .wrap_mode(wrap_mode),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_oldrd(ret_oldrd), .ret_data(ret_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_port(rd_port), .rd_rd(rd_rd),
    .rd_oldrd(rd_oldrd), .rd_data(rd_data), .rd_cycle(rd_cycle), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .cycle_cnt(cycle_cnt),
    .retired_cnt(retired_cnt), .dropped_cnt(dropped_cnt)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Old tag is always the dest tag + 32, so expectations follow from rd alone.
  task automatic drive(input logic [1:0] v, input logic [5:0] rd0, input logic [5:0] rd1,
                       input logic [31:0] d0, input logic [31:0] d1);
    ret_valid = v;
    ret_rd    = {rd1, rd0};
    ret_oldrd = {rd1 + 6'd32, rd0 + 6'd32};
    ret_data  = {d1, d0};
  endtask

  task automatic expect_entry(input logic [0:0] port, input logic [5:0] rd,
                              input logic [31:0] data, input logic [31:0] cyc);
    exp_entry_t e;
    e.port  = port;
    e.rd    = rd;
    e.oldrd = rd + 6'd32;
    e.data  = data;
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // Scoreboard monitor: a handshake on the coming edge consumes the head.
  always @(negedge tb_clk) begin
    if (rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got entry rd=0x%0h data=0x%0h, expected none", rd_rd, rd_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_port",  64'(rd_port),  64'(mon_e.port));
        check("sb_rd",    64'(rd_rd),    64'(mon_e.rd));
        check("sb_oldrd", 64'(rd_oldrd), 64'(mon_e.oldrd));
        check("sb_data",  64'(rd_data),  64'(mon_e.data));
        check("sb_cycle", 64'(rd_cycle), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; wrap_mode = 1'b0; rd_ready = 1'b0;
    drive(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    repeat (3) step();
    rst = 1'b1;
    check("rst_count",    64'(count), 64'd0);
    check("rst_empty",    64'(empty), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data",  64'(rd_data), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Two-port push stamped with cycle 3, then drained in port order.
    en = 1'b1;
    repeat (3) step();
    check("cyc_before_push", 64'(cycle_cnt), 64'd3);
    drive(2'b11, 6'd5, 6'd7, 32'd10, 32'd20);
    expect_entry(1'b0, 6'd5, 32'd10, 32'd3);
    expect_entry(1'b1, 6'd7, 32'd20, 32'd3);
    step();
    drive(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    check("dual_count",   64'(count), 64'd2);
    check("dual_retired", 64'(retired_cnt), 64'd2);
    check("dual_head_rd", 64'(rd_rd), 64'd5);
    rd_ready = 1'b1;
    repeat (2) step();
    rd_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);

    // Only port 1 valid: lands at the head with no hole.
    drive(2'b10, 6'd0, 6'd9, 32'd0, 32'h99);
    expect_entry(1'b1, 6'd9, 32'h99, 32'd6);
    step();
    check("p1_count",   64'(count), 64'd1);
    check("p1_rd_port", 64'(rd_port), 64'd1);
    check("p1_rd_rd",   64'(rd_rd), 64'd9);

    // Fill to three entries.
    drive(2'b11, 6'd11, 6'd12, 32'hA1, 32'hA2);
    expect_entry(1'b0, 6'd11, 32'hA1, 32'd7);
    expect_entry(1'b1, 6'd12, 32'hA2, 32'd7);
    step();
    check("fill_count",    64'(count), 64'd3);
    check("fill_overflow", 64'(overflow), 64'd0);

    // Stop mode, one free slot: port 0 accepted, port 1 dropped.
    drive(2'b11, 6'd13, 6'd14, 32'hB1, 32'hB2);
    expect_entry(1'b0, 6'd13, 32'hB1, 32'd8);
    step();
    check("stop_count",    64'(count), 64'd4);
    check("stop_full",     64'(full), 64'd1);
    check("stop_overflow", 64'(overflow), 64'd1);
    check("stop_dropped",  64'(dropped_cnt), 64'd1);

    // Stop mode, full, with a pop: the freed slot takes port 0.
    rd_ready = 1'b1;
    drive(2'b11, 6'd15, 6'd16, 32'hC1, 32'hC2);
    expect_entry(1'b0, 6'd15, 32'hC1, 32'd9);
    step();
    rd_ready = 1'b0;
    check("stoppop_count",   64'(count), 64'd4);
    check("stoppop_dropped", 64'(dropped_cnt), 64'd2);
    check("stoppop_head",    64'(rd_data), 64'hA1);

    // Wrap mode, full A1,A2,B1,C1: push two, oldest two overwritten.
    wrap_mode = 1'b1;
    drive(2'b11, 6'd17, 6'd18, 32'hD1, 32'hD2);
    void'(sb.pop_front());
    void'(sb.pop_front());
    expect_entry(1'b0, 6'd17, 32'hD1, 32'd10);
    expect_entry(1'b1, 6'd18, 32'hD2, 32'd10);
    step();
    check("wrap_count",    64'(count), 64'd4);
    check("wrap_dropped",  64'(dropped_cnt), 64'd4);
    check("wrap_overflow", 64'(overflow), 64'd1);
    check("wrap_head",     64'(rd_data), 64'hB1);
    check("wrap_retired",  64'(retired_cnt), 64'd11);

    // Wrap mode with a pop: the pop makes room, nothing is overwritten.
    rd_ready = 1'b1;
    drive(2'b01, 6'd19, 6'd0, 32'hE1, 32'd0);
    expect_entry(1'b0, 6'd19, 32'hE1, 32'd11);
    step();
    rd_ready = 1'b0;
    check("wrappop_count",   64'(count), 64'd4);
    check("wrappop_dropped", 64'(dropped_cnt), 64'd4);
    check("wrappop_head",    64'(rd_data), 64'hC1);

    // Clear overrides the pending push.
    clear = 1'b1;
    drive(2'b11, 6'd30, 6'd31, 32'hF0, 32'hF0);
    sb.delete();
    step();
    clear = 1'b0;
    check("clr_empty",    64'(empty), 64'd1);
    check("clr_rd_valid", 64'(rd_valid), 64'd0);
    check("clr_cycle",    64'(cycle_cnt), 64'd0);
    check("clr_retired",  64'(retired_cnt), 64'd0);
    check("clr_dropped",  64'(dropped_cnt), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);

    // en=0: no pushes, counters hold.
    en = 1'b0;
    repeat (5) step();
    check("dis_cycle",   64'(cycle_cnt), 64'd0);
    check("dis_count",   64'(count), 64'd0);
    check("dis_retired", 64'(retired_cnt), 64'd0);

    // Rebuild three entries, then assert reset mid-cycle.
    en = 1'b1;
    wrap_mode = 1'b0;
    drive(2'b01, 6'd20, 6'd0, 32'hF1, 32'd0);
    step();
    drive(2'b11, 6'd21, 6'd22, 32'hF2, 32'hF3);
    step();
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_cycle", 64'(cycle_cnt), 64'd2);
    en = 1'b0;
    drive(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count",   64'(count), 64'd0);
    check("arst_empty",   64'(empty), 64'd1);
    check("arst_valid",   64'(rd_valid), 64'd0);
    check("arst_cycle",   64'(cycle_cnt), 64'd0);
    check("arst_retired", 64'(retired_cnt), 64'd0);
    step();
    rst = 1'b1;

    // Push after reset, drain with en=0 (pop is independent of en).
    en = 1'b1;
    drive(2'b11, 6'd23, 6'd24, 32'h61, 32'h62);
    expect_entry(1'b0, 6'd23, 32'h61, 32'd0);
    expect_entry(1'b1, 6'd24, 32'h62, 32'd0);
    step();
    en = 1'b0;
    drive(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    rd_ready = 1'b1;
    begin
      int budget;
      budget = 10;
      while (rd_valid && budget > 0) begin
        step();
        budget--;
      end
      check("drain_timeout", 64'(rd_valid), 64'd0);
    end
    rd_ready = 1'b0;
    check("final_sb_left", 64'(sb.size()), 64'd0);
    check("final_cycle",   64'(cycle_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
